// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key expander.
// Holds the forward and inverse S-box tables, the round-constant table and
// the word/byte typedefs used across the AES datapath.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Round constants indexed by the 4-bit round counter; rounds 10..15 use zero
  // so the expander can keep free-running after the last real round.
  localparam byte_t RCON [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Byte rotation used by the key schedule: {a,b,c,d} -> {b,c,d,a}.
  function automatic word_t rotateWord(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_128_sbox.sv
// AES byte substitution, forward (s=1) or inverse (s=0), purely combinational.
module sbox
  import aes_pkg::*;
(
  input  logic       s,
  input  logic [7:0] a,
  output logic [7:0] d
);

  // Table lookup selected by direction.
  always_comb begin
    d = s ? SBOX_FWD[a] : SBOX_INV[a];
  end

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 key expander: produces one round key per cycle after a key load.
// Optional feature: define AES_KEY_EXPAND_DONE_EN to add the key_done pulse
// that marks the cycle round key 10 is presented on wo_0..wo_3.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3
`ifdef AES_KEY_EXPAND_DONE_EN
  ,
  output logic         key_done
`endif
);

  word_t      w0_q, w1_q, w2_q, w3_q;
  word_t      w0_d, w1_d, w2_d, w3_d;
  logic [3:0] roundCnt_q, roundCnt_d;
  logic       keyLoaded_q, keyLoaded_d;
  word_t      rotWord;
  word_t      subWord;
  word_t      tempWord;

  assign rotWord = rotateWord(w3_q);

  sbox uSbox0 (.s(1'b1), .a(rotWord[31:24]), .d(subWord[31:24]));
  sbox uSbox1 (.s(1'b1), .a(rotWord[23:16]), .d(subWord[23:16]));
  sbox uSbox2 (.s(1'b1), .a(rotWord[15:8]),  .d(subWord[15:8]));
  sbox uSbox3 (.s(1'b1), .a(rotWord[7:0]),   .d(subWord[7:0]));

  // Next round key: load on kld, otherwise advance one schedule step.
  // Until a key has been loaded since reset the words stay at zero.
  always_comb begin
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    w3_d        = w3_q;
    roundCnt_d  = roundCnt_q;
    keyLoaded_d = keyLoaded_q;
    tempWord    = subWord ^ {RCON[roundCnt_q], 24'h0};
    if (kld) begin
      w0_d        = key[127:96];
      w1_d        = key[95:64];
      w2_d        = key[63:32];
      w3_d        = key[31:0];
      roundCnt_d  = 4'd0;
      keyLoaded_d = 1'b1;
    end else if (keyLoaded_q) begin
      w0_d = w0_q ^ tempWord;
      w1_d = w1_q ^ w0_d;
      w2_d = w2_q ^ w1_d;
      w3_d = w3_q ^ w2_d;
      roundCnt_d = (roundCnt_q == 4'hf) ? roundCnt_q : roundCnt_q + 4'd1;
    end
  end

  // Round-key and counter registers; reset wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      w3_q        <= '0;
      roundCnt_q  <= '0;
      keyLoaded_q <= 1'b0;
    end else begin
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      w3_q        <= w3_d;
      roundCnt_q  <= roundCnt_d;
      keyLoaded_q <= keyLoaded_d;
    end
  end

  assign wo_0 = w0_q;
  assign wo_1 = w1_q;
  assign wo_2 = w2_q;
  assign wo_3 = w3_q;

`ifdef AES_KEY_EXPAND_DONE_EN
  logic keyDone_q, keyDone_d;

  // Done fires on the step that takes the counter from 9 to 10.
  always_comb begin
    keyDone_d = !kld && keyLoaded_q && (roundCnt_q == 4'd9);
  end

  // Registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyDone_q <= 1'b0;
    end else begin
      keyDone_q <= keyDone_d;
    end
  end

  assign key_done = keyDone_q;
`endif

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Scoreboard bench for aes_key_expand_128 with a FIPS-197 style reference
// schedule built from GF(2^8) arithmetic; also exercises the sbox unit.
module tb_aes_key_expand_128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         kld = 1'b0;
  logic [127:0] key = '0;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
`ifdef AES_KEY_EXPAND_DONE_EN
  logic         key_done;
`endif

  logic       sbS = 1'b1;
  logic [7:0] sbA = 8'h00;
  logic [7:0] sbD;

  aes_key_expand_128 dut (
    .clk  (clk),
    .rst  (rst),
    .kld  (kld),
    .key  (key),
    .wo_0 (wo_0),
    .wo_1 (wo_1),
    .wo_2 (wo_2),
    .wo_3 (wo_3)
`ifdef AES_KEY_EXPAND_DONE_EN
    ,
    .key_done (key_done)
`endif
  );

  sbox uSboxChk (.s(sbS), .a(sbA), .d(sbD));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] w;
    bit           done;
    string        name;
  } exp_t;

  exp_t        sbQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  refSbox [256];
  logic [31:0] sched [260];
  bit          modelLoaded = 1'b0;
  int          modelIdx = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] r;
      logic [7:0] acc;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gfMul(inv, 8'(v));
      end
      acc = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        acc = acc ^ r;
      end
      refSbox[v] = acc;
    end
  endtask

  function automatic logic [7:0] rconRef(input int j);
    logic [7:0] rc = 8'h01;
    if (j >= 10) return 8'h00;
    for (int k = 0; k < j; k++) rc = xtime(rc);
    return rc;
  endfunction

  // Standard word recurrence, continued past round 10 with a zero constant.
  task automatic expandKey(input logic [127:0] kv);
    logic [31:0] t;
    sched[0] = kv[127:96];
    sched[1] = kv[95:64];
    sched[2] = kv[63:32];
    sched[3] = kv[31:0];
    for (int i = 4; i < 260; i++) begin
      t = sched[i-1];
      if (i % 4 == 0) begin
        t = {refSbox[t[23:16]], refSbox[t[15:8]], refSbox[t[7:0]], refSbox[t[31:24]]}
            ^ {rconRef(i/4 - 1), 24'h0};
      end
      sched[i] = sched[i-4] ^ t;
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic applyStimulus(input bit r, input bit k, input logic [127:0] kv,
                               input bit useLit, input logic [127:0] lit, input string name);
    exp_t e;
    @(negedge clk);
    rst = r;
    kld = k;
    key = kv;
    if (r) begin
      modelLoaded = 1'b0;
      modelIdx = 0;
    end else if (k) begin
      expandKey(kv);
      modelLoaded = 1'b1;
      modelIdx = 0;
    end else if (modelLoaded && modelIdx < 64) begin
      modelIdx++;
    end
    e.w = modelLoaded ? {sched[4*modelIdx], sched[4*modelIdx+1], sched[4*modelIdx+2], sched[4*modelIdx+3]}
                      : 128'h0;
    if (useLit) e.w = lit;
    e.done = modelLoaded && !r && !k && (modelIdx == 10);
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [127:0] got;
    bit bad = 1'b0;
    got = {wo_0, wo_1, wo_2, wo_3};
    vectors++;
    if (got !== e.w) begin
      $display("[TB] FAIL %s: wo got %h expected %h", e.name, got, e.w);
      bad = 1'b1;
    end
`ifdef AES_KEY_EXPAND_DONE_EN
    if (key_done !== e.done) begin
      $display("[TB] FAIL %s_done: key_done got %b expected %b", e.name, key_done, e.done);
      bad = 1'b1;
    end
`endif
    if (bad) miscompares++;
  endtask

  // Monitor: every cycle the DUT presents a round key, compare with the queue head.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() != 0) begin
        m = sbQ.pop_front();
        checkOutput(m);
      end
    end
  end

  initial begin
    logic [127:0] kv;
    buildSbox();

    for (int x = 0; x < 256; x++) begin
      sbS = 1'b1;
      sbA = 8'(x);
      #1;
      vectors++;
      if (sbD !== refSbox[x]) begin
        $display("[TB] FAIL sbox_fwd: a=%h got %h expected %h", sbA, sbD, refSbox[x]);
        miscompares++;
      end
      sbS = 1'b0;
      sbA = refSbox[x];
      #1;
      vectors++;
      if (sbD !== 8'(x)) begin
        $display("[TB] FAIL sbox_inv: a=%h got %h expected %h", sbA, sbD, 8'(x));
        miscompares++;
      end
    end

    applyStimulus(1, 0, '0, 0, '0, "reset");
    applyStimulus(1, 0, '0, 0, '0, "reset");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 128'hdeadbeef, 1, '0, "idle_after_reset");

    applyStimulus(0, 1, FIPS_KEY, 1, FIPS_KEY, "fips_r0");
    applyStimulus(0, 0, '0, 1, FIPS_R1, "fips_r1");
    applyStimulus(0, 0, '0, 1, FIPS_R2, "fips_r2");
    for (int r = 3; r < 10; r++) applyStimulus(0, 0, '0, 0, '0, "fips_rn");
    applyStimulus(0, 0, '0, 1, FIPS_R10, "fips_r10");
    for (int r = 0; r < 8; r++) applyStimulus(0, 0, '0, 0, '0, "fips_free");

    applyStimulus(0, 1, '0, 1, '0, "zero_r0");
    applyStimulus(0, 0, '0, 1, ZERO_R1, "zero_r1");
    applyStimulus(0, 0, '0, 1, ZERO_R2, "zero_r2");
    for (int r = 3; r < 6; r++) applyStimulus(0, 0, '0, 0, '0, "zero_rn");
    applyStimulus(0, 1, '0, 1, '0, "reload_r0");
    applyStimulus(0, 0, '0, 1, ZERO_R1, "reload_r1");

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, FIPS_KEY, 1, FIPS_KEY, "kld_held");
    applyStimulus(0, 0, '0, 1, FIPS_R1, "kld_held_r1");

    applyStimulus(1, 1, FIPS_KEY, 1, '0, "rst_with_kld");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, FIPS_KEY, 1, '0, "rst_kld_idle");

    for (int seg = 0; seg < 40; seg++) begin
      kv = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) kv = '0;
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) applyStimulus(0, 1, kv, 0, '0, "rand_load");
      for (int i = 0; i < int'($urandom_range(1, 25)); i++) begin
        kv = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 39) == 0) begin
          applyStimulus(1, $urandom_range(0, 1) == 1, kv, 0, '0, "rand_rst");
        end else if ($urandom_range(0, 29) == 0) begin
          applyStimulus(0, 1, kv, 0, '0, "rand_abort");
        end else begin
          applyStimulus(0, 0, kv, 0, '0, "rand_run");
        end
      end
    end

    for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(posedge clk);
    #2;
    if (sbQ.size() != 0) begin
      $display("[TB] FAIL drain_timeout: pending %0d expected 0", sbQ.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
